blink_top: RTL and testbench



---
 rtl/blink_pkg.sv | 37 +++
 rtl/blink_prescaler.sv | 54 +++++
 rtl/blink_top.sv | 74 +++++++
 tb/tb_blink_top.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/blink_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | blink_pkg : shared constants and segment encoder for blink_top        |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package blink_pkg;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  localparam int NUM_HEX = 6;
  localparam int LED_W   = 16;

  typedef logic [2:0] seg_idx_t;

  localparam seg_idx_t SEG_LAST = 3'd5;

  // Active-low pattern: one of a..f lit, g always dark, dp lit while clk_1hz is high.
  function automatic logic [7:0] seg_pattern(input seg_idx_t seg, input logic clk_1hz);
    logic [7:0] p;
    p                = SEG_OFF;
    p[SEG_F:SEG_A]   = ~(6'b000001 << seg);
    p[SEG_G]         = 1'b1;
    p[SEG_DP]        = ~clk_1hz;
    return p;
  endfunction

endpackage
`default_nettype wire

// File: rtl/blink_prescaler.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | blink_prescaler : divides clk into 2 Hz / 1 Hz timebases + step pulse |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module blink_prescaler #(
  parameter int CLK_HZ = 10_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic clk_2hz,
  output logic clk_1hz,
  output logic step
);

  localparam int HALF_CNT = CLK_HZ / 4;
  localparam int CNT_W    = $clog2(HALF_CNT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_CNT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_2hz_q, clk_2hz_d;
  logic             clk_1hz_q, clk_1hz_d;
  logic             step_q, step_d;
  logic             wrap;

  // step and clk_1hz change on the same edge that takes clk_2hz from 0 to 1.
  always_comb begin
    wrap      = (cnt_q == CNT_LAST);
    cnt_d     = wrap ? '0 : cnt_q + CNT_W'(1);
    clk_2hz_d = clk_2hz_q ^ wrap;
    step_d    = wrap & ~clk_2hz_q;
    clk_1hz_d = clk_1hz_q ^ step_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q     <= '0;
      clk_2hz_q <= 1'b0;
      clk_1hz_q <= 1'b0;
      step_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      clk_2hz_q <= clk_2hz_d;
      clk_1hz_q <= clk_1hz_d;
      step_q    <= step_d;
    end
  end

  assign clk_2hz = clk_2hz_q;
  assign clk_1hz = clk_1hz_q;
  assign step    = step_q;

endmodule
`default_nettype wire

// File: rtl/blink_top.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | blink_top : walking-one LEDs and segment chaser on six 7-seg displays |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module blink_top
  import blink_pkg::*;
#(
  parameter int CLK_HZ = 10_000_000
) (
  input  logic             clk,
  input  logic             rst,
  output logic [7:0]       sthex0,
  output logic [7:0]       sthex1,
  output logic [7:0]       sthex2,
  output logic [7:0]       sthex3,
  output logic [7:0]       sthex4,
  output logic [7:0]       sthex5,
  output logic [LED_W-1:0] stled
);

  logic clk_2hz;
  logic clk_1hz;
  logic step;
  logic adv;

  blink_prescaler #(
    .CLK_HZ (CLK_HZ)
  ) u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .clk_2hz (clk_2hz),
    .clk_1hz (clk_1hz),
    .step    (step)
  );

  logic [LED_W-1:0] stled_q, stled_d;
  seg_idx_t         seg_q, seg_d;
  logic [7:0]       hex_q, hex_d;

  // step only ever fires in the high half of clk_2hz; qualifying keeps both tied together.
  always_comb begin
    adv     = step & clk_2hz;
    stled_d = stled_q;
    seg_d   = seg_q;
    if (adv) begin
      stled_d = {stled_q[LED_W-2:0], stled_q[LED_W-1]};
      seg_d   = (seg_q >= SEG_LAST) ? '0 : seg_q + 3'd1;
    end
    hex_d = seg_pattern(seg_d, clk_1hz);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stled_q <= LED_W'(1);
      seg_q   <= '0;
      hex_q   <= seg_pattern('0, 1'b0);
    end else begin
      stled_q <= stled_d;
      seg_q   <= seg_d;
      hex_q   <= hex_d;
    end
  end

  assign stled  = stled_q;
  assign sthex0 = hex_q;
  assign sthex1 = hex_q;
  assign sthex2 = hex_q;
  assign sthex3 = hex_q;
  assign sthex4 = hex_q;
  assign sthex5 = hex_q;

endmodule
`default_nettype wire

// File: tb/tb_blink_top.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_blink_top : scoreboard bench for blink_top at CLK_HZ = 40          |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_blink_top;

  localparam int CLK_HZ   = 40;
  localparam int HALF     = CLK_HZ / 4;
  localparam int STEP_CYC = CLK_HZ / 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  sthex0, sthex1, sthex2, sthex3, sthex4, sthex5;
  logic [15:0] stled;

  blink_top #(
    .CLK_HZ (CLK_HZ)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .sthex0 (sthex0),
    .sthex1 (sthex1),
    .sthex2 (sthex2),
    .sthex3 (sthex3),
    .sthex4 (sthex4),
    .sthex5 (sthex5),
    .stled  (stled)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] led;
    logic [7:0]  hex;
    int          due;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  logic mon_en = 1'b0;

  // Display pattern for segment index 0..5 with dp dark.
  logic [7:0] seg_tbl [6] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [15:0] led, input logic [7:0] hex);
    logic [7:0] hx [6];
    hx = '{sthex0, sthex1, sthex2, sthex3, sthex4, sthex5};
    check({tag, "_led"}, 32'(stled), 32'(led));
    for (int i = 0; i < 6; i++)
      check($sformatf("%s_hex%0d", tag, i), 32'(hx[i]), 32'(hex));
  endtask

  // Step k after a release at cycle rel: walking LED, segment k mod 6, dp lit on odd k.
  task automatic push_steps(input int rel, input int n);
    for (int k = 1; k <= n; k++) begin
      exp_t e;
      e.led = 16'h0001 << (k % 16);
      e.hex = seg_tbl[k % 6] & (((k % 2) == 1) ? 8'h7F : 8'hFF);
      e.due = rel + HALF + 1 + STEP_CYC * (k - 1);
      q.push_back(e);
    end
  endtask

  // Monitor: every visible output change consumes one scoreboard entry.
  logic [63:0] prev = '0;
  always @(negedge clk) begin
    logic [63:0] cur;
    exp_t        e;
    cur = {stled, sthex0, sthex1, sthex2, sthex3, sthex4, sthex5};
    if (mon_en && (cur !== prev)) begin
      if (q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_change: got led=%h hex0=%h at cycle %0d, want no change",
                 stled, sthex0, cyc);
      end else begin
        e = q.pop_front();
        check_outputs("step", e.led, e.hex);
        check("step_cycle", 32'(cyc), 32'(e.due));
      end
    end
    prev = cur;
  end

  initial begin
    int rel;
    int last_due;
    exp_t r;

    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_outputs("reset", 16'h0001, 8'hFE);
    end

    rel    = cyc;
    rst    = 1'b1;
    mon_en = 1'b1;
    push_steps(rel, 7);

    // Pulse reset mid-count, a few cycles after the seventh step lands.
    while (cyc < rel + HALF + 1 + STEP_CYC * 6 + 4) @(negedge clk);
    rst   = 1'b0;
    r.led = 16'h0001;
    r.hex = 8'hFE;
    r.due = cyc + 1;
    q.push_back(r);
    @(negedge clk);
    rst = 1'b1;
    rel = cyc;
    push_steps(rel, 18);

    last_due = rel + HALF + 1 + STEP_CYC * 17;
    while (cyc < last_due + 5) @(negedge clk);
    check("queue_drained", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end of test, want finish before 200000");
    $fatal(1);
  end

endmodule
`default_nettype wire
